// File: rtl/dma_prog_regs_if.sv
// rtl/dma_prog_regs_if.sv - host I/O strobe bus between the CPU bus interface and dma_prog_regs
interface dma_prog_regs_if;
    logic       CS_N;
    logic       IOR_N;
    logic       IOW_N;
    logic       HLDA;
    logic [3:0] ADDR_L;
    logic [7:0] DB_IN;
    logic [7:0] DB_OUT;
    logic       DB_OE;

    modport master (
        output CS_N, IOR_N, IOW_N, HLDA, ADDR_L, DB_IN,
        input  DB_OUT, DB_OE
    );

    modport slave (
        input  CS_N, IOR_N, IOW_N, HLDA, ADDR_L, DB_IN,
        output DB_OUT, DB_OE
    );
endinterface

// File: rtl/dma_prog_regs.sv
// rtl/dma_prog_regs.sv - DMA programming registers: channel address/count, mode, mask, command, status
// Define DMA_AUTOINIT_EN to reload a channel's current registers from base on TC when its autoinit mode bit is set.
module dma_prog_regs #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 16
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    dma_prog_regs_if.slave           bus,
    input  logic [NUM_CH-1:0]        REQ,
    input  logic [NUM_CH-1:0]        TC,
    input  logic [NUM_CH-1:0]        UPD_VALID,
    input  logic [NUM_CH*ADDR_W-1:0] UPD_ADDR,
    input  logic [NUM_CH*ADDR_W-1:0] UPD_WC,
    output logic [NUM_CH*ADDR_W-1:0] CURR_ADDR,
    output logic [NUM_CH*ADDR_W-1:0] CURR_WC,
    output logic [NUM_CH*6-1:0]      MODE,
    output logic [NUM_CH-1:0]        MASK,
    output logic [7:0]               COMMAND
);
    localparam int         NB      = ADDR_W / 8;
    localparam logic [1:0] BP_LAST = 2'(NB - 1);
    localparam logic [1:0] MP_LAST = 2'(NUM_CH - 1);

    logic              r_iow_q;
    logic              r_ior_q;
    logic [1:0]        r_bp;
    logic [1:0]        r_mp;
    logic [ADDR_W-1:0] r_base_addr [NUM_CH];
    logic [ADDR_W-1:0] r_base_wc   [NUM_CH];
    logic [ADDR_W-1:0] r_cur_addr  [NUM_CH];
    logic [ADDR_W-1:0] r_cur_wc    [NUM_CH];
    logic [5:0]        r_mode      [NUM_CH];
    logic [NUM_CH-1:0] r_mask;
    logic [NUM_CH-1:0] r_tc;
    logic [7:0]        r_command;
    logic [7:0]        r_db_out;
    logic              r_db_oe;

    logic              w_wr;
    logic              w_rd;
    logic              w_mclr;
    logic [1:0]        w_ch;
    logic              w_ch_ok;
    logic [NUM_CH-1:0] w_wr_addr;
    logic [NUM_CH-1:0] w_wr_wc;
    logic [NUM_CH-1:0] w_reload;
    logic [ADDR_W-1:0] w_cur_word;
    logic [7:0]        w_cur_byte;
    logic [5:0]        w_mode_sel;
    logic [7:0]        w_rd_data;

    // An access is the first cycle of a falling strobe; a held strobe or both strobes low never repeats it.
    assign w_wr    = !bus.CS_N && !bus.HLDA && bus.IOR_N && r_iow_q && !bus.IOW_N;
    assign w_rd    = !bus.CS_N && !bus.HLDA && bus.IOW_N && r_ior_q && !bus.IOR_N;
    assign w_mclr  = w_wr && (bus.ADDR_L == 4'hD);
    assign w_ch    = bus.ADDR_L[2:1];
    assign w_ch_ok = !bus.ADDR_L[3] && ({1'b0, w_ch} < 3'(NUM_CH));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_iow_q <= 1'b1;
            r_ior_q <= 1'b1;
        end else begin
            r_iow_q <= bus.IOW_N;
            r_ior_q <= bus.IOR_N;
        end
    end

    always_comb begin
        w_wr_addr = '0;
        w_wr_wc   = '0;
        w_reload  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_wr_addr[c] = w_wr && w_ch_ok && (w_ch == 2'(c)) && !bus.ADDR_L[0];
            w_wr_wc[c]   = w_wr && w_ch_ok && (w_ch == 2'(c)) &&  bus.ADDR_L[0];
`ifdef DMA_AUTOINIT_EN
            w_reload[c]  = TC[c] && r_mode[c][2];
`else
            w_reload[c]  = 1'b0;
`endif
        end
    end

    always_comb begin
        w_cur_word = '0;
        w_cur_byte = '0;
        w_mode_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_ch == 2'(c)) begin
                w_cur_word = bus.ADDR_L[0] ? r_cur_wc[c] : r_cur_addr[c];
            end
            if (r_mp == 2'(c)) begin
                w_mode_sel = r_mode[c];
            end
        end
        for (int b = 0; b < NB; b++) begin
            if (r_bp == 2'(b)) begin
                w_cur_byte = w_cur_word[b*8 +: 8];
            end
        end
        w_rd_data = '0;
        if (!bus.ADDR_L[3]) begin
            if (w_ch_ok) begin
                w_rd_data = w_cur_byte;
            end
        end else begin
            case (bus.ADDR_L[2:0])
                3'd0:    w_rd_data = {4'(REQ), 4'(r_tc)};
                3'd3:    w_rd_data = {w_mode_sel, r_mp};
                3'd7:    w_rd_data = 8'(r_mask);
                default: w_rd_data = '0;
            endcase
        end
    end

    // Current registers: a host byte write wins over an autoinit reload, which wins over engine write-back.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_base_addr[c] <= '0;
                r_base_wc[c]   <= '0;
                r_cur_addr[c]  <= '0;
                r_cur_wc[c]    <= '0;
            end
        end else if (w_mclr) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_base_addr[c] <= '0;
                r_base_wc[c]   <= '0;
                r_cur_addr[c]  <= '0;
                r_cur_wc[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_wr_addr[c]) begin
                    for (int b = 0; b < NB; b++) begin
                        if (r_bp == 2'(b)) begin
                            r_base_addr[c][b*8 +: 8] <= bus.DB_IN;
                            r_cur_addr[c][b*8 +: 8]  <= bus.DB_IN;
                        end
                    end
                end else if (w_reload[c]) begin
                    r_cur_addr[c] <= r_base_addr[c];
                end else if (UPD_VALID[c]) begin
                    r_cur_addr[c] <= UPD_ADDR[c*ADDR_W +: ADDR_W];
                end
                if (w_wr_wc[c]) begin
                    for (int b = 0; b < NB; b++) begin
                        if (r_bp == 2'(b)) begin
                            r_base_wc[c][b*8 +: 8] <= bus.DB_IN;
                            r_cur_wc[c][b*8 +: 8]  <= bus.DB_IN;
                        end
                    end
                end else if (w_reload[c]) begin
                    r_cur_wc[c] <= r_base_wc[c];
                end else if (UPD_VALID[c]) begin
                    r_cur_wc[c] <= UPD_WC[c*ADDR_W +: ADDR_W];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_bp <= '0;
            r_mp <= '0;
        end else if (w_mclr) begin
            r_bp <= '0;
            r_mp <= '0;
        end else begin
            if ((w_wr || w_rd) && w_ch_ok) begin
                r_bp <= (r_bp == BP_LAST) ? 2'd0 : r_bp + 2'd1;
            end else if (w_wr && (bus.ADDR_L == 4'hC)) begin
                r_bp <= '0;
            end else if (w_rd && (bus.ADDR_L == 4'hC)) begin
                r_bp <= BP_LAST;
            end
            if (w_wr && (bus.ADDR_L == 4'hC)) begin
                r_mp <= '0;
            end else if (w_rd && (bus.ADDR_L == 4'hB)) begin
                r_mp <= (r_mp == MP_LAST) ? 2'd0 : r_mp + 2'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_command <= '0;
            r_mask    <= '1;
            r_tc      <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_mode[c] <= '0;
            end
        end else if (w_mclr) begin
            r_command <= '0;
            r_mask    <= '1;
            r_tc      <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_mode[c] <= '0;
            end
        end else begin
            // A status read clears the latch but a same-cycle TC still lands.
            if (w_rd && (bus.ADDR_L == 4'h8)) begin
                r_tc <= TC;
            end else begin
                r_tc <= r_tc | TC;
            end
            if (w_wr) begin
                case (bus.ADDR_L)
                    4'h8: r_command <= bus.DB_IN;
                    4'hA: begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (bus.DB_IN[1:0] == 2'(c)) begin
                                r_mask[c] <= bus.DB_IN[2];
                            end
                        end
                    end
                    4'hB: begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (bus.DB_IN[1:0] == 2'(c)) begin
                                r_mode[c] <= bus.DB_IN[7:2];
                            end
                        end
                    end
                    4'hE:    r_mask <= '0;
                    4'hF:    r_mask <= bus.DB_IN[NUM_CH-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_db_out <= '0;
            r_db_oe  <= 1'b0;
        end else if (w_mclr) begin
            r_db_out <= '0;
            r_db_oe  <= 1'b0;
        end else begin
            if (w_rd) begin
                r_db_out <= w_rd_data;
            end
            if (w_rd) begin
                r_db_oe <= 1'b1;
            end else if (bus.IOR_N) begin
                r_db_oe <= 1'b0;
            end
        end
    end

    always_comb begin
        CURR_ADDR = '0;
        CURR_WC   = '0;
        MODE      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            CURR_ADDR[c*ADDR_W +: ADDR_W] = r_cur_addr[c];
            CURR_WC[c*ADDR_W +: ADDR_W]   = r_cur_wc[c];
            MODE[c*6 +: 6]                = r_mode[c];
        end
    end

    assign MASK       = r_mask;
    assign COMMAND    = r_command;
    assign bus.DB_OUT = r_db_out;
    assign bus.DB_OE  = r_db_oe;
endmodule

// File: doc/dma_prog_regs.md
# dma_prog_regs

Parametrised programming-register block for the DMA controller. It turns CPU I/O strobes into one-shot register accesses and holds the per-channel base/current address and word-count registers, the mode, mask, command and status registers, and a multi-byte byte-pointer counter. It sits between the CPU bus interface and the transfer engine. It exports current values to the engine and accepts write-backs from it.

## Interface
- NUM_CH, 4: channel count, legal 1..4.
- ADDR_W, 16: address/word-count width, multiple of 8, legal 8..32; NB = ADDR_W/8 bytes per register.

- CLK  in  1  clock.
- RESET_N  in  1  reset, asynchronous, active-low.
- CS_N, IOR_N, IOW_N  in  1 each  chip select, read strobe, write strobe; all active-low and synchronous to CLK.
- HLDA  in  1  hold acknowledge; high = engine owns the bus, host accesses ignored.
- ADDR_L  in  4  register offset.
- DB_IN  in  8  host write data.
- DB_OUT  out  8  host read data, registered.
- DB_OE  out  1  read data enable.
- REQ  in  NUM_CH  raw DREQ levels, for status only.
- TC  in  NUM_CH  terminal-count pulse per channel, one cycle.
- UPD_VALID  in  NUM_CH  engine write-back strobe per channel.
- UPD_ADDR, UPD_WC  in  NUM_CH*ADDR_W  engine write-back values.
- CURR_ADDR, CURR_WC  out  NUM_CH*ADDR_W  current registers.
- MODE  out  NUM_CH*6  mode bits DB[7:2] per channel.
- MASK  out  NUM_CH  1 = channel masked.
- COMMAND  out  8  command register.

## Operation
- Access detect: the block registers IOW_N and IOR_N each cycle; both register to 1 on reset.
- A write access is one cycle with CS_N=0, HLDA=0, IOR_N=1, IOW_N falling (previous 1, now 0). A read access is the same with the strobes swapped.
- A held strobe produces exactly one access. Accesses with HLDA=1 or CS_N=1 have no side effects.
- Offsets 2i and 2i+1, for i < NUM_CH, address channel i's address and word-count registers.
  - Write: byte BP of base and current is loaded from DB_IN.
  - Read: DB_OUT = byte BP of the current register.
  - Either access advances BP; BP wraps from NB-1 to 0.
  - Offsets 2i with i ≥ NUM_CH: write ignored, read returns 0, BP unchanged.
- 0x8 write: COMMAND = DB_IN.
- 0x8 read: returns {REQ zero-padded to 4 bits, TC-latch zero-padded to 4 bits}. TC-latch bits are cleared by this read.
- 0x9: write ignored, read returns 0.
- 0xA write (single mask): DB_IN[1:0] = channel, DB_IN[2] = value. Ignored if the channel is ≥ NUM_CH.
- 0xB write: MODE[DB_IN[1:0]] = DB_IN[7:2]. Ignored if the channel is ≥ NUM_CH.
- 0xB read: returns {MODE[mp], 2'(mp)}; mp then increments modulo NUM_CH. mp is cleared by 0xC write and by master clear.
- 0xC write: BP = 0. 0xC read: BP = NB-1, returns 0.
- 0xD write (master clear): every register returns to its reset value.
- 0xE write: MASK = all 0.
- 0xF write: MASK = DB_IN[NUM_CH-1:0]. 0xF read: returns MASK zero-extended.
- TC[i] sets TC-latch bit i.
- UPD_VALID[i] loads channel i's current registers from UPD_ADDR and UPD_WC.
- Same-cycle priority on a channel's current registers: host write > autoinit reload (see Configuration) > UPD_VALID.
- Status read in the same cycle as TC[i]: bit i is left set, so the TC is not lost.

## Timing
- Reset values (RESET_N low, or master clear, both take effect immediately):
  - DB_OUT=0, DB_OE=0.
  - All base and current registers 0.
  - MODE=0, MASK=all 1, COMMAND=0.
  - TC-latch=0, BP=0, mp=0.
- Write commits at the clock edge that detects the access. The new value is visible on outputs the following cycle.
- Read data: DB_OUT is loaded at the detect edge and held while IOR_N=0. DB_OE=1 from the cycle after detect until the cycle after IOR_N returns high.
- Side effects of a read (BP advance, mp increment, TC clear) occur at the detect edge.
- IOR_N and IOW_N both low: no access.
- Engine write-back and TC take effect one cycle after assertion.

## Configuration
- DMA_AUTOINIT_EN defined: on TC[i] with MODE[i] bit 2 (= DB_IN[4], autoinit) set, channel i's current registers reload from base on the next cycle. The reload is overridden by a same-cycle host write to that register.
- DMA_AUTOINIT_EN undefined: TC only sets the TC-latch. The autoinit mode bit is stored and read back but has no effect.

## Test plan
- Program, ADDR_W=16: 0xC write, then 0x0 writes 0x34 then 0x12. Expect CURR_ADDR[ch0]=0x1234. Two 0x0 reads return 0x34 then 0x12, and BP ends at 0.
- Byte wrap, ADDR_W=24: three writes 0x11, 0x22, 0x33 to offset 0x3. Expect CURR_WC[ch1]=0x332211. A fourth write of 0x44 gives 0x332244.
- Strobe: IOW_N held low for 5 cycles on 0x0. Expect BP to advance exactly once. Repeat with HLDA=1: no register change.
- Status: pulse TC[2], then read 0x8 with REQ=4'b0001. Expect 0x14, and an immediate re-read gives 0x10. TC[3] in the same cycle as the read leaves bit 3 set.
- Masks: 0xE write then 0xA write 0x05 gives MASK=4'b0010. 0xF read returns 0x02. 0xD write gives MASK=4'b1111, COMMAND=0.
- Autoinit (macro on): base 0x0100 on ch3 with mode autoinit set, then UPD_VALID with 0x0180, then TC[3]. Expect CURR_ADDR[ch3]=0x0100 one cycle later. With the macro off it stays 0x0180.
